// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit register file for the write-back stage.
//   clk         system clock, rising-edge updates
//   rst_n       asynchronous active-low reset, clears registers and counter
//   RegWrite    write enable
//   write_reg   destination index, write_data the value to commit
//   read_reg1/2 combinational read ports -> read_data1/2 (optionally write-first)
//   dbg_addr    debug read port -> dbg_data, always the stored value
//   wr_count    committed writes since reset, wraps silently
module reg_file #(
  parameter bit BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWrite,
  input  logic [4:0]  write_reg,
  input  logic [31:0] write_data,
  input  logic [4:0]  read_reg1,
  input  logic [4:0]  read_reg2,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic [31:0] wr_count
);
  logic [31:0] regs_q [1:31];
  logic [31:0] regs_d [1:31];
  logic [31:0] wr_count_q, wr_count_d;
  logic        we;
  logic        byp1, byp2;
  // index 0 never commits and never counts
  assign we = RegWrite && (write_reg != 5'd0);
  always_comb begin
    regs_d     = regs_q;
    wr_count_d = wr_count_q;
    if (we) begin
      regs_d[write_reg] = write_data;
      wr_count_d        = wr_count_q + 32'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q     <= '{default: 32'd0};
      wr_count_q <= 32'd0;
    end else begin
      regs_q     <= regs_d;
      wr_count_q <= wr_count_d;
    end
  end
  function automatic logic [31:0] stored(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : regs_q[a];
  endfunction
  // bypass is suppressed while reset is held so outputs stay at zero
  assign byp1 = BYPASS && rst_n && we && (read_reg1 == write_reg);
  assign byp2 = BYPASS && rst_n && we && (read_reg2 == write_reg);
  assign read_data1 = byp1 ? write_data : stored(read_reg1);
  assign read_data2 = byp2 ? write_data : stored(read_reg2);
  assign dbg_data   = stored(dbg_addr);
  assign wr_count   = wr_count_q;
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: checks reg_file (write-first and read-old builds) against an array model.
module tb_reg_file;
  logic        clk = 1'b0;
  logic        rst_n, regw;
  logic [4:0]  wa, r1, r2, da;
  logic [31:0] wd;
  logic [31:0] rd1_b, rd2_b, dbg_b, cnt_b, rd1_o, rd2_o, dbg_o, cnt_o;
  logic [31:0] mregs [0:31];
  logic [31:0] mcount;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  reg_file #(.BYPASS(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .RegWrite(regw), .write_reg(wa), .write_data(wd),
    .read_reg1(r1), .read_reg2(r2), .read_data1(rd1_b), .read_data2(rd2_b),
    .dbg_addr(da), .dbg_data(dbg_b), .wr_count(cnt_b)
  );
  reg_file #(.BYPASS(1'b0)) u_o (
    .clk(clk), .rst_n(rst_n), .RegWrite(regw), .write_reg(wa), .write_data(wd),
    .read_reg1(r1), .read_reg2(r2), .read_data1(rd1_o), .read_data2(rd2_o),
    .dbg_addr(da), .dbg_data(dbg_o), .wr_count(cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_byp(input logic [4:0] a);
    return (rst_n && regw && wa != 5'd0 && a == wa) ? wd : mregs[a];
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".rd1_b"}, rd1_b, m_byp(r1));
    check({tag, ".rd2_b"}, rd2_b, m_byp(r2));
    check({tag, ".rd1_o"}, rd1_o, mregs[r1]);
    check({tag, ".rd2_o"}, rd2_o, mregs[r2]);
    check({tag, ".dbg_b"}, dbg_b, mregs[da]);
    check({tag, ".dbg_o"}, dbg_o, mregs[da]);
    check({tag, ".cnt_b"}, cnt_b, mcount);
    check({tag, ".cnt_o"}, cnt_o, mcount);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    mcount = 32'd0;
  endtask

  task automatic step(input string tag, input logic w, input logic [4:0] a, input logic [31:0] d,
                      input logic [4:0] p1, input logic [4:0] p2, input logic [4:0] pd);
    regw = w; wa = a; wd = d; r1 = p1; r2 = p2; da = pd;
    #1 check_all({tag, ".pre"});
    @(posedge clk);
    if (rst_n && w && a != 5'd0) begin
      mregs[a] = d;
      mcount   = mcount + 32'd1;
    end
    #1 check_all({tag, ".post"});
  endtask

  initial begin
    rst_n = 1'b0; regw = 1'b0; wa = 5'd0; wd = 32'd0; r1 = 5'd0; r2 = 5'd0; da = 5'd0;
    model_reset();
    // reset held: every address reads zero, even with a write presented
    for (int i = 0; i < 32; i++) begin
      r1 = 5'(i); r2 = 5'(31 - i); da = 5'(i); regw = 1'b1; wa = 5'(i); wd = 32'hA5A5A5A5;
      #1;
      check("rst.rd1_b", rd1_b, 32'd0);
      check("rst.rd2_b", rd2_b, 32'd0);
      check("rst.dbg_o", dbg_o, 32'd0);
      check("rst.cnt_b", cnt_b, 32'd0);
    end
    @(posedge clk); #1;
    check("rst.edge_cnt", cnt_b, 32'd0);
    regw = 1'b0;
    rst_n = 1'b1;
    #1 check_all("rel");
    // basic writes
    step("w5", 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd31, 5'd5);
    step("w31", 1'b1, 5'd31, 32'h00000031, 5'd5, 5'd31, 5'd31);
    regw = 1'b0;
    for (int i = 0; i < 32; i++) begin
      da = 5'(i);
      #1 check("basic.dbg", dbg_b, (i == 5) ? 32'hDEADBEEF : (i == 31) ? 32'h00000031 : 32'd0);
    end
    check("basic.cnt", cnt_b, 32'd2);
    // register 0 ignores writes and does not count
    step("r0", 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
    check("r0.rd1", rd1_b, 32'd0);
    check("r0.cnt", cnt_o, 32'd2);
    // bypass vs read-old on r8
    step("r8a", 1'b1, 5'd8, 32'h11111111, 5'd0, 5'd0, 5'd8);
    regw = 1'b1; wa = 5'd8; wd = 32'h22222222; r1 = 5'd8; r2 = 5'd8; da = 5'd8;
    #1;
    check("byp.rd1_b", rd1_b, 32'h22222222);
    check("byp.rd2_b", rd2_b, 32'h22222222);
    check("byp.rd1_o", rd1_o, 32'h11111111);
    check("byp.rd2_o", rd2_o, 32'h11111111);
    check("byp.dbg_b", dbg_b, 32'h11111111);
    check("byp.dbg_o", dbg_o, 32'h11111111);
    step("r8b", 1'b1, 5'd8, 32'h22222222, 5'd8, 5'd8, 5'd8);
    check("byp.after_o", rd1_o, 32'h22222222);
    // async reset with r3 = 12345678 and wr_count = 7 while a write to r3 is pending
    rst_n = 1'b0; model_reset(); #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step("fill", 1'b1, 5'(10 + i), 32'(i + 1), 5'd3, 5'(10 + i), 5'd3);
    step("r3", 1'b1, 5'd3, 32'h12345678, 5'd3, 5'd3, 5'd3);
    check("ar.cnt7", cnt_b, 32'd7);
    regw = 1'b1; wa = 5'd3; wd = 32'hCAFEF00D; r1 = 5'd3; r2 = 5'd3; da = 5'd3;
    #2 rst_n = 1'b0; model_reset();
    #1;
    check("ar.rd1_b", rd1_b, 32'd0);
    check("ar.rd1_o", rd1_o, 32'd0);
    check("ar.dbg", dbg_b, 32'd0);
    check("ar.cnt", cnt_b, 32'd0);
    @(posedge clk); #1;
    check("ar.edge_rd", dbg_o, 32'd0);
    check("ar.edge_cnt", cnt_o, 32'd0);
    rst_n = 1'b1;
    step("ar.rw", 1'b1, 5'd3, 32'h0BADBEEF, 5'd3, 5'd0, 5'd3);
    check("ar.cnt1", cnt_b, 32'd1);
    check("ar.r3", dbg_b, 32'h0BADBEEF);
    // randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        #2 rst_n = 1'b0; model_reset();
        #1 check_all("rnd.rst");
        @(posedge clk); #1 rst_n = 1'b1;
      end
      step("rnd", 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom(),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    // counter wrap from FFFFFFFE
    regw = 1'b0;
    force u_b.wr_count_q = 32'hFFFFFFFE;
    force u_o.wr_count_q = 32'hFFFFFFFE;
    #1;
    release u_b.wr_count_q;
    release u_o.wr_count_q;
    mcount = 32'hFFFFFFFE;
    step("wrap1", 1'b1, 5'd1, 32'h1, 5'd1, 5'd2, 5'd1);
    check("wrap.ffffffff", cnt_b, 32'hFFFFFFFF);
    step("wrap2", 1'b1, 5'd1, 32'h2, 5'd1, 5'd2, 5'd1);
    check("wrap.0", cnt_b, 32'h00000000);
    step("wrap3", 1'b1, 5'd1, 32'h3, 5'd1, 5'd2, 5'd1);
    check("wrap.1", cnt_o, 32'h00000001);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file.md
# reg_file

Register file on the write-back end of the single-cycle datapath: it accepts the value chosen by the write-back select stage (ALU result, memory data, jal link address or slt result) and commits it to one of 32 general-purpose registers. It provides two asynchronous read ports for the decode stage and a debug read port for the bench. It also keeps a count of committed writes. Register 0 reads as zero at all times.

## Interface
- BYPASS, 1, when 1, a read of the register being written this cycle returns write_data (write-first); when 0, it returns the stored value (read-old)
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- RegWrite  in  1  write enable from control
- write_reg  in  5  destination register index (rd/rt/31 already selected upstream)
- write_data  in  32  value from write-back select
- read_reg1  in  5  rs index
- read_reg2  in  5  rt index
- read_data1  out  32  contents of read_reg1
- read_data2  out  32  contents of read_reg2
- dbg_addr  in  5  debug read index
- dbg_data  out  32  contents of dbg_addr (never bypassed)
- wr_count  out  32  number of committed writes since reset

## Operation
- Storage: 31 physical 32-bit registers, indices 1..31. Index 0 has no storage and always reads 32'd0.
- Commit: on the rising clk edge with rst_n high, RegWrite=1 and write_reg!=0, regs[write_reg] <= write_data. In the same edge, wr_count <= wr_count+1.
- A write to index 0 is discarded and does not increment wr_count. RegWrite=0 leaves all state unchanged.
- Reads: read_data1/2 and dbg_data are combinational functions of the address inputs and the stored state.
- Bypass (BYPASS=1): if rst_n=1, RegWrite=1, write_reg!=0 and read_regN==write_reg, then read_data N = write_data. Otherwise it is the stored value. Bypass never applies to index 0 or dbg_data.
- Both read ports may address the same register. Either port may match write_reg independently.
- wr_count is 32-bit unsigned and wraps from 32'hFFFFFFFF to 0 without a flag.
- Reset: asserting rst_n low clears regs[1..31] and wr_count to 0 immediately, without waiting for clk. While rst_n is low, writes are ignored and bypass is disabled. Reset asserted mid-cycle overrides any pending write. The first commit can occur on the first rising edge after rst_n goes high.
- X/undefined write_reg with RegWrite=0 has no effect.

## Timing
- Write latency: 1 clock. Data is visible on a non-bypassed read after the commit edge.
- Read latency: 0 cycles, purely combinational from address/state (and write_data/RegWrite when bypassing).
- Outputs during and immediately after reset: read_data1, read_data2 and dbg_data are 0 for every address. wr_count is 0.
- Simultaneous read of a register and a write to it in the same cycle:
  - BYPASS=1: new value.
  - BYPASS=0: old value until the edge, new value after.
- No handshake; one write per cycle maximum, every cycle.

## Test plan
- Reset: hold rst_n=0, sweep read_reg1/read_reg2/dbg_addr over 0..31 -> all outputs 0, wr_count=0. Release rst_n -> values unchanged until the first write.
- Basic write/read: write 32'hDEADBEEF to r5, then 32'h00000031 to r31 -> dbg_data at 5 and 31 return those values, wr_count=2, every other register reads 0.
- Register 0: RegWrite=1, write_reg=0, write_data=32'hFFFFFFFF -> read_data1 at index 0 = 0 both before and after the edge, and wr_count unchanged.
- Bypass: BYPASS=1, r8 holds 32'h11111111; in one cycle write 32'h22222222 to r8 with read_reg1=read_reg2=8 -> both ports show 32'h22222222 before the edge. With BYPASS=0 the same stimulus shows 32'h11111111 before the edge and 32'h22222222 after it; dbg_data at 8 shows the old value before the edge in both cases.
- Async reset mid-operation: r3 holds 32'h12345678 and wr_count=7; drop rst_n between edges while a write to r3 is pending -> r3 and wr_count read 0 immediately. Re-write r3 after release -> wr_count=1.
- Counter wrap: force wr_count to 32'hFFFFFFFE, perform 3 writes to r1 -> wr_count sequence FFFFFFFF, 00000000, 00000001.
